register_file: RTL and testbench



---
 rtl/register_file.sv | 110 +++++++++++
 tb/tb_register_file.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   Architectural register file: DEPTH x DATA_WIDTH flops, two independent
//   combinational read ports and one write port that commits on the rising edge
//   of clk. It sits between operand fetch (reads) and writeback (write).
//
//   Ports
//     clk       system clock, all state updates on the rising edge
//     reset     synchronous active-high reset, clears every entry
//     read_en   per-port read enable (bit 0 = port 0, bit 1 = port 1)
//     write_en  write enable
//     raddr_0   read address, port 0
//     raddr_1   read address, port 1
//     waddr     write address
//     wdata     write data
//     rdata_0   read data, port 0 (0 when read_en[0] is low)
//     rdata_1   read data, port 1 (0 when read_en[1] is low)
//
//   Build option
//     REGFILE_WRITE_BYPASS_EN  when defined, a read that hits the address being
//                              written in the same cycle returns wdata instead
//                              of the pre-write contents. Default: undefined.
//
//   Entry 0 is an ordinary register, not hardwired to zero.
//   DEPTH must equal 2**ADDR_WIDTH, so every address is in range.
// -----------------------------------------------------------------------------

// One read port: a DEPTH:1 mux over the storage with an optional forwarding
// override. The output is forced to 0 when the port is disabled so downstream
// operand latches never see stale data.
module register_file_read_port #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 16
) (
   input  logic                             en,
   input  logic [ADDR_WIDTH-1:0]            addr,
   input  logic [DEPTH-1:0][DATA_WIDTH-1:0] entries,
   input  logic                             fwd,
   input  logic [DATA_WIDTH-1:0]            fwd_data,
   output logic [DATA_WIDTH-1:0]            rdata
);

   always_comb begin
      rdata = '0;
      if (en) begin
         if (fwd) rdata = fwd_data;
         else     rdata = entries[addr];
      end
   end

endmodule

module register_file #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            read_en,
   input  logic                  write_en,
   input  logic [ADDR_WIDTH-1:0] raddr_0,
   input  logic [ADDR_WIDTH-1:0] raddr_1,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata_0,
   output logic [DATA_WIDTH-1:0] rdata_1
);

   localparam int NUM_PORTS = 2;

   logic [DEPTH-1:0][DATA_WIDTH-1:0]      entries;
   logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  raddr;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rdata;

   // Reset wins over a coincident write; that write is simply lost.
   always_ff @(posedge clk) begin
      if (reset)         entries        <= '0;
      else if (write_en) entries[waddr] <= wdata;
   end

   assign raddr   = {raddr_1, raddr_0};
   assign rdata_0 = rdata[0];
   assign rdata_1 = rdata[1];

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
      logic fwd;
`ifdef REGFILE_WRITE_BYPASS_EN
      // Forward only a write that will actually commit at the next edge.
      assign fwd = write_en & ~reset & (raddr[p] == waddr);
`else
      // Same-cycle reads see the pre-write contents.
      assign fwd = 1'b0;
`endif
      register_file_read_port #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH),
         .DEPTH      (DEPTH)
      ) u_port (
         .en       (read_en[p]),
         .addr     (raddr[p]),
         .entries  (entries),
         .fwd      (fwd),
         .fwd_data (wdata),
         .rdata    (rdata[p])
      );
   end

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//   Directed bench for register_file. A plain array holds what every register
//   must contain; a negedge process checks both read ports against it each
//   cycle, and literal checks at fixed points pin the array itself.
// -----------------------------------------------------------------------------
module tb_register_file;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  read_en;
   logic        write_en;
   logic [3:0]  raddr_0, raddr_1, waddr;
   logic [63:0] wdata;
   logic [63:0] rdata_0, rdata_1;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   logic [63:0] model [16];

   register_file dut (
      .clk      (clk),
      .reset    (reset),
      .read_en  (read_en),
      .write_en (write_en),
      .raddr_0  (raddr_0),
      .raddr_1  (raddr_1),
      .waddr    (waddr),
      .wdata    (wdata),
      .rdata_0  (rdata_0),
      .rdata_1  (rdata_1)
   );

   always #5 clk = ~clk;

   // Architectural state as the spec defines it.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) model[i] <= '0;
      end else if (write_en) begin
         model[waddr] <= wdata;
      end
   end

   function automatic logic [63:0] expect_read(input logic en, input logic [3:0] a);
      if (!en) return 64'd0;
`ifdef REGFILE_WRITE_BYPASS_EN
      if (write_en && !reset && a == waddr) return wdata;
`endif
      return model[a];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("cyc_rdata_0", rdata_0, expect_read(read_en[0], raddr_0));
         check("cyc_rdata_1", rdata_1, expect_read(read_en[1], raddr_1));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rst, input logic [1:0] re, input logic [3:0] r0,
                        input logic [3:0] r1, input logic we, input logic [3:0] wa,
                        input logic [63:0] wd);
      reset = rst; read_en = re; raddr_0 = r0; raddr_1 = r1;
      write_en = we; waddr = wa; wdata = wd;
   endtask

   logic [63:0] last [16];
   logic [63:0] d;
   logic [1:0]  pat;

   initial begin
      drive(1'b1, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 64'd0);
      step();
      // Reset state
      drive(1'b0, 2'b11, 4'd0, 4'd15, 1'b0, 4'd0, 64'd0);
      chk_on = 1'b1;
      #1;
      check("reset_p0", rdata_0, 64'd0);
      check("reset_p1", rdata_1, 64'd0);

      // Basic write/read
      drive(1'b0, 2'b00, 4'd0, 4'd0, 1'b1, 4'd0, 64'h0123456789ABCDEF);
      step();
      drive(1'b0, 2'b01, 4'd0, 4'd0, 1'b0, 4'd0, 64'd0);
      #1;
      check("basic_p0", rdata_0, 64'h0123456789ABCDEF);
      check("basic_p0_off1", rdata_1, 64'd0);
      step();
      read_en = 2'b10;
      #1;
      check("basic_p1", rdata_1, 64'h0123456789ABCDEF);
      check("basic_p1_off0", rdata_0, 64'd0);
      step();
      read_en = 2'b11;
      #1;
      check("basic_both_0", rdata_0, 64'h0123456789ABCDEF);
      check("basic_both_1", rdata_1, 64'h0123456789ABCDEF);
      step();

      // Sweep: 128 writes per address, alternating write and readback cycles
      for (int a = 0; a < 16; a++) last[a] = (a == 0) ? 64'h0123456789ABCDEF : 64'd0;
      for (int a = 0; a < 16; a++) begin
         for (int i = 0; i < 128; i++) begin
            d = {$urandom, $urandom};
            drive(1'b0, 2'b11, 4'(a), 4'(a + i + 1), 1'b1, 4'(a), d);
            step();
            last[a] = d;
            pat = 2'(i % 3 + 1);
            drive(1'b0, pat, 4'(a), (pat == 2'b11) ? 4'(a) : 4'(a + i + 1), 1'b0, 4'(a), 64'd0);
            step();
         end
      end
      read_en = 2'b11; write_en = 1'b0;
      for (int a = 0; a < 16; a++) begin
         raddr_0 = 4'(a); raddr_1 = 4'(15 - a);
         #1;
         check("sweep_last_p0", rdata_0, last[a]);
         check("sweep_last_p1", rdata_1, last[15 - a]);
         step();
      end

      // Disable
      drive(1'b0, 2'b00, 4'd5, 4'd5, 1'b1, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF);
      step();
      drive(1'b0, 2'b00, 4'd5, 4'd5, 1'b0, 4'd0, 64'd0);
      #1;
      check("dis_00_p0", rdata_0, 64'd0);
      check("dis_00_p1", rdata_1, 64'd0);
      read_en = 2'b01;
      #1;
      check("dis_01_p0", rdata_0, 64'hFFFF_FFFF_FFFF_FFFF);
      check("dis_01_p1", rdata_1, 64'd0);
      step();

      // Same-cycle collision on address 3
      drive(1'b0, 2'b00, 4'd3, 4'd3, 1'b1, 4'd3, 64'hAA);
      step();
      drive(1'b0, 2'b11, 4'd3, 4'd3, 1'b1, 4'd3, 64'h55);
      #1;
`ifdef REGFILE_WRITE_BYPASS_EN
      check("coll_pre_p0", rdata_0, 64'h55);
      check("coll_pre_p1", rdata_1, 64'h55);
`else
      check("coll_pre_p0", rdata_0, 64'hAA);
      check("coll_pre_p1", rdata_1, 64'hAA);
`endif
      step();
      write_en = 1'b0;
      #1;
      check("coll_post_p0", rdata_0, 64'h55);
      check("coll_post_p1", rdata_1, 64'h55);

      // Mid-cycle reset has no effect until the edge
      reset = 1'b1;
      #1;
      check("midrst_p0", rdata_0, 64'h55);
      step();
      reset = 1'b0;
      #1;
      check("rst_clear_p0", rdata_0, 64'd0);

      // Write 7, then reset and write at the same edge: reset wins
      drive(1'b0, 2'b00, 4'd7, 4'd7, 1'b1, 4'd7, 64'h9999);
      step();
      drive(1'b1, 2'b11, 4'd7, 4'd7, 1'b1, 4'd7, 64'h1234);
      step();
      drive(1'b0, 2'b11, 4'd7, 4'd7, 1'b0, 4'd0, 64'd0);
      #1;
      check("rst_vs_wr_p0", rdata_0, 64'd0);
      check("rst_vs_wr_p1", rdata_1, 64'd0);
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
